// File: rtl/mult_job_sequencer.sv
// Job sequencer for the add/shift signed multiplier datapath: queues operand pairs,
// steps the datapath through WIDTH add/shift pairs per job and hands back each product.
module mult_job_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_mcand,
    input  logic [WIDTH-1:0]     in_mplier,
    output logic [WIDTH-1:0]     dp_mcand,
    output logic [WIDTH-1:0]     dp_mplier,
    output logic                 dp_load,
    output logic                 dp_add,
    output logic                 dp_sub,
    output logic                 dp_shift,
    input  logic                 dp_m,
    input  logic [2*WIDTH-1:0]   dp_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_prod,
    output logic                 busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(WIDTH - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // ---------------- job FIFO ----------------
    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic [2*WIDTH-1:0] head;

    state_t             state_q;

    // in_ready depends only on the occupancy register, never on this cycle's pop
    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign in_ready = ~full;
    assign push     = in_valid & ~full;
    assign pop      = (state_q == S_IDLE) & ~empty;
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_mcand, in_mplier};
        end
    end

    // ---------------- step sequencer ----------------
    logic [SW-1:0]    cnt_q;
    logic [WIDTH-1:0] dp_mcand_q;
    logic [WIDTH-1:0] dp_mplier_q;
    logic             load_q;
    logic             add_ph_q;
    logic             shift_q;
    logic             out_valid_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dp_mcand_q  <= '0;
            dp_mplier_q <= '0;
            load_q      <= 1'b0;
            add_ph_q    <= 1'b0;
            shift_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!empty) begin
                        dp_mcand_q  <= head[2*WIDTH-1:WIDTH];
                        dp_mplier_q <= head[WIDTH-1:0];
                        load_q      <= 1'b1;
                        state_q     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    load_q   <= 1'b0;
                    cnt_q    <= '0;
                    add_ph_q <= 1'b1;
                    state_q  <= S_ADD;
                end
                S_ADD: begin
                    add_ph_q <= 1'b0;
                    shift_q  <= 1'b1;
                    state_q  <= S_SHIFT;
                end
                S_SHIFT: begin
                    shift_q <= 1'b0;
                    if (cnt_q == LAST_STEP) begin
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        cnt_q    <= cnt_q + SW'(1);
                        add_ph_q <= 1'b1;
                        state_q  <= S_ADD;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    load_q      <= 1'b0;
                    add_ph_q    <= 1'b0;
                    shift_q     <= 1'b0;
                    out_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    // Add/sub must follow the live B[0] of the datapath, so they are gated here
    // rather than registered; the sign-weighted top bit is subtracted.
    assign dp_add    = add_ph_q & (cnt_q != LAST_STEP) & dp_m;
    assign dp_sub    = add_ph_q & (cnt_q == LAST_STEP) & dp_m;
    assign dp_load   = load_q;
    assign dp_shift  = shift_q;
    assign dp_mcand  = dp_mcand_q;
    assign dp_mplier = dp_mplier_q;
    assign out_valid = out_valid_q;
    assign out_prod  = dp_result;
    assign busy      = (state_q != S_IDLE) | ~empty;

endmodule

// File: tb/tb_mult_job_sequencer.sv
// Bench for mult_job_sequencer: behavioural add/shift datapath, directed jobs,
// scoreboard queue checked by an independent output monitor.
module tb_mult_job_sequencer;

    localparam int W = 8;
    localparam int D = 4;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_mcand = '0;
    logic [W-1:0]  in_mplier = '0;
    logic [W-1:0]  dp_mcand;
    logic [W-1:0]  dp_mplier;
    logic          dp_load, dp_add, dp_sub, dp_shift;
    logic          dp_m;
    logic [2*W-1:0] dp_result;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [2*W-1:0] out_prod;
    logic          busy;

    mult_job_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
        .Clk(Clk), .Reset(Reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mcand(in_mcand), .in_mplier(in_mplier),
        .dp_mcand(dp_mcand), .dp_mplier(dp_mplier),
        .dp_load(dp_load), .dp_add(dp_add), .dp_sub(dp_sub), .dp_shift(dp_shift),
        .dp_m(dp_m), .dp_result(dp_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod),
        .busy(busy)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Behavioural datapath: {X,A,B} with S holding the multiplicand.
    logic [W-1:0] a_q = '0;
    logic [W-1:0] b_q = '0;
    logic [W-1:0] s_q = '0;
    logic         x_q = 1'b0;
    always @(posedge Clk) begin
        if (dp_load) begin
            a_q <= '0;
            x_q <= 1'b0;
            b_q <= dp_mplier;
            s_q <= dp_mcand;
        end else if (dp_add) begin
            {x_q, a_q} <= {a_q[W-1], a_q} + {s_q[W-1], s_q};
        end else if (dp_sub) begin
            {x_q, a_q} <= {a_q[W-1], a_q} - {s_q[W-1], s_q};
        end else if (dp_shift) begin
            {x_q, a_q, b_q} <= {x_q, x_q, a_q, b_q[W-1:1]};
        end
    end
    assign dp_m      = b_q[0];
    assign dp_result = {a_q, b_q};

    typedef struct {
        logic [2*W-1:0] prod;
        int             adds;
        int             subs;
    } exp_t;

    exp_t sb_q[$];
    int   out_cyc_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: strobe sanity every cycle, product/strobe counts on each handshake.
    initial begin
        int n_add, n_sub, n_shift;
        exp_t e;
        n_add = 0; n_sub = 0; n_shift = 0;
        forever begin
            @(negedge Clk);
            if (!Reset) begin
                chk("strobe_onehot",
                    32'($countones({dp_load, dp_add, dp_sub, dp_shift}) <= 1), 32'd1);
                if (out_valid)
                    chk("done_strobes_quiet", 32'({dp_load, dp_add, dp_sub, dp_shift}), 32'd0);
                if (dp_load) begin
                    n_add = 0; n_sub = 0; n_shift = 0;
                end
                if (dp_add)   n_add++;
                if (dp_sub)   n_sub++;
                if (dp_shift) n_shift++;
                if (out_valid && out_ready) begin
                    out_cyc_q.push_back(cyc);
                    if (sb_q.size() == 0) begin
                        chk("unexpected_output", 32'(out_prod), 32'hDEAD_0000);
                    end else begin
                        e = sb_q.pop_front();
                        $display("out prod=%04h expected=%04h adds=%0d subs=%0d shifts=%0d cycle=%0d",
                                 out_prod, e.prod, n_add, n_sub, n_shift, cyc);
                        chk("out_prod", 32'(out_prod), 32'(e.prod));
                        chk("add_count", 32'(n_add), 32'(e.adds));
                        chk("sub_count", 32'(n_sub), 32'(e.subs));
                        chk("shift_count", 32'(n_shift), 32'd8);
                    end
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push_job(input logic [W-1:0] mc, input logic [W-1:0] mp,
                            input logic [2*W-1:0] prod);
        exp_t e;
        bit   ok;
        ok = 0;
        in_valid  = 1'b1;
        in_mcand  = mc;
        in_mplier = mp;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge Clk);
            if (in_ready) ok = 1;
            @(posedge Clk);
        end
        if (ok) begin
            e.prod = prod;
            e.adds = $countones(mp[W-2:0]);
            e.subs = int'(mp[W-1]);
            sb_q.push_back(e);
            $display("push mcand=%0d mplier=%0d expect=%04h cycle=%0d",
                     $signed(mc), $signed(mp), prod, cyc);
        end else begin
            chk("push_timeout", 32'd0, 32'd1);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge Clk);
            if (out_valid) ok = 1;
        end
        if (!ok) chk("wait_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 0;
        for (int k = 0; k < 3000 && !ok; k++) begin
            @(negedge Clk);
            if (sb_q.size() == 0 && !busy && !out_valid) ok = 1;
        end
        chk("drain", 32'(ok), 32'd1);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int  p, loads, acc, a, b;
        bit  ok, rdy;
        logic [W-1:0] bp_mc [5];
        logic [W-1:0] bp_mp [5];
        logic [2*W-1:0] bp_pr [5];

        // ---- reset state ----
        #2 Reset = 1'b1;
        #5;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_strobes", 32'({dp_load, dp_add, dp_sub, dp_shift}), 32'd0);
        chk("rst_dp_operands", 32'({dp_mcand, dp_mplier}), 32'd0);
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        @(posedge Clk);
        #1;

        // ---- single job 3 x 5 with latency ----
        out_ready = 1'b1;
        p = cyc;
        push_job(8'd3, 8'd5, 16'h000F);
        wait_valid(ok);
        if (ok) chk("latency_3x5", 32'(cyc - p), 32'd19);
        wait_drain();

        // ---- signed corners ----
        push_job(8'hFD, 8'd5,  16'hFFF1);
        push_job(8'h80, 8'h80, 16'h4000);
        push_job(8'd127, 8'h80, 16'hC080);
        push_job(8'd0, 8'hFF,  16'h0000);
        wait_drain();

        // ---- fill with out_ready low, then release ----
        out_ready = 1'b0;
        out_cyc_q.delete();
        push_job(8'd1,   8'd1,   16'h0001);
        chk("fill_ready_1", 32'(in_ready), 32'd1);
        push_job(8'd2,   8'd3,   16'h0006);
        chk("fill_ready_2", 32'(in_ready), 32'd1);
        push_job(8'hFF,  8'hFF,  16'h0001);
        chk("fill_ready_3", 32'(in_ready), 32'd1);
        push_job(8'd10,  8'hF6,  16'hFF9C);
        chk("fill_ready_4", 32'(in_ready), 32'd1);
        push_job(8'd100, 8'd100, 16'h2710);
        chk("fill_ready_5", 32'(in_ready), 32'd0);
        wait_valid(ok);
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_prod", 32'(out_prod), 32'h0001);
            chk("bp_full_ready", 32'(in_ready), 32'd0);
        end
        @(posedge Clk);
        #1 out_ready = 1'b1;
        @(negedge Clk);
        chk("release_ready_done", 32'(in_ready), 32'd0);
        @(negedge Clk);
        chk("release_ready_pop", 32'(in_ready), 32'd0);
        @(negedge Clk);
        chk("release_ready_after_pop", 32'(in_ready), 32'd1);
        @(posedge Clk);
        #1;
        wait_drain();
        chk("fill_out_count", 32'(out_cyc_q.size()), 32'd5);
        for (int i = 1; i < out_cyc_q.size(); i++)
            chk("fill_spacing", 32'(out_cyc_q[i] - out_cyc_q[i-1]), 32'd19);

        // ---- backpressure in DONE with concurrent pushes ----
        bp_mc = '{8'd3, 8'hFE, 8'd5, 8'hF9, 8'd6};
        bp_mp = '{8'd3, 8'd4, 8'hFF, 8'hF9, 8'd6};
        bp_pr = '{16'h0009, 16'hFFF8, 16'hFFFB, 16'h0031, 16'h0024};
        push_job(8'd7, 8'hF7, 16'hFFC1);
        out_ready = 1'b0;
        wait_valid(ok);
        @(posedge Clk);
        #1;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid  = (acc < 5);
            in_mcand  = bp_mc[acc < 5 ? acc : 4];
            in_mplier = bp_mp[acc < 5 ? acc : 4];
            @(negedge Clk);
            rdy = in_ready;
            chk("bp2_valid", 32'(out_valid), 32'd1);
            chk("bp2_prod", 32'(out_prod), 32'hFFC1);
            @(posedge Clk);
            if (in_valid && rdy) begin
                exp_t e;
                e.prod = bp_pr[acc];
                e.adds = $countones(bp_mp[acc][W-2:0]);
                e.subs = int'(bp_mp[acc][W-1]);
                sb_q.push_back(e);
                $display("push mcand=%0d mplier=%0d expect=%04h cycle=%0d",
                         $signed(bp_mc[acc]), $signed(bp_mp[acc]), bp_pr[acc], cyc);
                acc++;
            end
            #1;
        end
        in_valid = 1'b0;
        chk("bp2_accepted", 32'(acc), 32'd4);
        chk("bp2_full", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        push_job(bp_mc[4], bp_mp[4], bp_pr[4]);
        wait_drain();

        // ---- simultaneous push and pop at DEPTH-1 ----
        out_ready = 1'b0;
        push_job(8'd4,  8'd5,  16'h0014);
        push_job(8'hFC, 8'd5,  16'hFFEC);
        push_job(8'd4,  8'hFB, 16'hFFEC);
        push_job(8'hFC, 8'hFB, 16'h0014);
        wait_valid(ok);
        @(posedge Clk);
        #1 out_ready = 1'b1;
        @(posedge Clk);
        #1;
        in_valid = 1'b1; in_mcand = 8'd9; in_mplier = 8'd9;
        @(negedge Clk);
        chk("pp_ready_before", 32'(in_ready), 32'd1);
        @(posedge Clk);
        begin
            exp_t e;
            e.prod = 16'h0051; e.adds = 2; e.subs = 0;
            sb_q.push_back(e);
        end
        #1;
        in_mcand = 8'hF7; in_mplier = 8'd9;
        @(negedge Clk);
        chk("pp_occupancy_same", 32'(in_ready), 32'd1);
        @(posedge Clk);
        begin
            exp_t e;
            e.prod = 16'hFFAF; e.adds = 2; e.subs = 0;
            sb_q.push_back(e);
        end
        #1 in_valid = 1'b0;
        @(negedge Clk);
        chk("pp_full_after_push", 32'(in_ready), 32'd0);
        @(posedge Clk);
        #1;
        wait_drain();

        // ---- pointer wrap over 3*DEPTH jobs ----
        for (int i = 0; i < 3 * D; i++) begin
            a = i * 11 - 60;
            b = 37 - i * 7;
            push_job(8'(a), 8'(b), 16'(a * b));
        end
        wait_drain();

        // ---- reset during SHIFT of job 2 of 3 ----
        push_job(8'd2, 8'd3, 16'h0006);
        push_job(8'd4, 8'd5, 16'h0014);
        push_job(8'd6, 8'd7, 16'h002A);
        loads = 0;
        ok = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge Clk);
            if (dp_load) loads++;
            if (loads == 2 && dp_shift) ok = 1;
        end
        chk("reach_job2_shift", 32'(ok), 32'd1);
        #1 Reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_strobes", 32'({dp_load, dp_add, dp_sub, dp_shift}), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_operands", 32'({dp_mcand, dp_mplier}), 32'd0);
        sb_q.delete();
        @(posedge Clk);
        #1 Reset = 1'b0;
        @(posedge Clk);
        #1;
        chk("post_rst_idle", 32'(busy), 32'd0);
        push_job(8'd2, 8'd2, 16'h0004);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mult_job_sequencer.md
# mult_job_sequencer

Sequencer that feeds the add/shift signed multiplier datapath from a small operand queue. Accepts signed operand pairs over a valid/ready handshake, buffers up to DEPTH jobs, and loads each job into the datapath. It then drives the WIDTH add/shift step pairs, with a subtract on the final step for two's-complement multipliers. Each product is returned over a valid/ready handshake. It replaces the per-step hard-coded controller and adds back-to-back job processing without software re-triggering Run.

## Interface
Parameters:
- WIDTH, 8, operand width; datapath product is 2*WIDTH.
- DEPTH, 4, job FIFO entries; power of two, >= 2.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  FIFO not full; equals ~full.
- in_mcand  in  WIDTH  signed multiplicand.
- in_mplier  in  WIDTH  signed multiplier.
- dp_mcand  out  WIDTH  registered multiplicand presented to datapath.
- dp_mplier  out  WIDTH  registered multiplier presented to datapath.
- dp_load  out  1  datapath clears A and X, loads B=dp_mplier and S=dp_mcand.
- dp_add  out  1  datapath performs A = A + S (sign-extended into X).
- dp_sub  out  1  datapath performs A = A - S.
- dp_shift  out  1  datapath arithmetic-shifts {X,A,B} right by 1.
- dp_m  in  1  current B[0] from datapath.
- dp_result  in  2*WIDTH  datapath {A,B}.
- out_valid  out  1  product available.
- out_ready  in  1  consumer accepts product.
- out_prod  out  2*WIDTH  equals dp_result; meaningful only while out_valid.
- busy  out  1  state != IDLE or FIFO non-empty.

## Operation
- FIFO: DEPTH entries of {mcand, mplier}, with read/write pointers and an occupancy count of width log2(DEPTH)+1.
  - Push when in_valid & in_ready.
  - Pop only in IDLE when non-empty.
  - Simultaneous push and pop are legal; occupancy is unchanged.
  - in_ready stays 0 while full, even on a pop cycle; it is not a combinational path from pop.
  - Pointers wrap modulo DEPTH.
- States: IDLE, LOAD, ADD, SHIFT, DONE. Step counter cnt ranges 0..WIDTH-1.
- IDLE: if the FIFO is non-empty, pop the head into the dp_mcand/dp_mplier registers and go to LOAD. Otherwise stay.
- LOAD: dp_load=1; cnt<=0; go to ADD.
- ADD: if cnt==WIDTH-1, dp_sub=dp_m; otherwise dp_add=dp_m. Go to SHIFT.
- SHIFT: dp_shift=1.
  - If cnt==WIDTH-1, go to DONE.
  - Otherwise cnt<=cnt+1 and go to ADD.
- DONE: out_valid=1; no datapath strobes, so dp_result is stable. On out_ready, go to IDLE.
- At most one of dp_load/dp_add/dp_sub/dp_shift is high in any cycle. All strobes are 0 in IDLE and DONE.
- dp_mcand/dp_mplier change only on the IDLE pop edge, and hold through the job.
- Result equals the signed product in_mcand*in_mplier, in 2*WIDTH bits.

## Timing
- Reset (async) forces:
  - state=IDLE, cnt=0, FIFO empty, pointers 0.
  - dp_mcand=dp_mplier=0.
  - All strobes 0, out_valid=0, busy=0, in_ready=1.
- Reset mid-job abandons the job and all queued entries. No partial out_valid is produced.
- Latency: push accepted at edge of cycle 0, then:
  - cycle 1: IDLE pop.
  - cycle 2: LOAD.
  - cycles 3..2*WIDTH+2: ADD/SHIFT.
  - cycle 2*WIDTH+3: first out_valid cycle (19 for WIDTH=8).
- Throughput: 2*WIDTH+3 cycles per job when out_ready is held high (IDLE, LOAD, 2W steps, DONE).
- out_valid stays asserted, and out_prod stays stable, until out_ready. Backpressure does not block FIFO pushes until the FIFO is full.
- Push into an empty FIFO while in IDLE: the pop happens on the following cycle. The FIFO has no bypass.

## Test plan
- Reset then single job 3 x 5 (WIDTH=8), out_ready=1:
  - out_prod=0x000F with out_valid at cycle 19 after the push.
  - Exactly 7 dp_add-eligible ADD cycles, 1 sub-eligible ADD cycle and 8 dp_shift pulses.
- Signed corners:
  - -3 x 5 -> 0xFFF1.
  - -128 x -128 -> 0x4000.
  - 127 x -128 -> 0xC080.
  - 0 x -1 -> 0x0000.
- Fill: push 5 jobs back-to-back with out_ready=0.
  - in_ready drops after the 5th accept (1 in flight + 4 queued).
  - Release out_ready: products emerge in order, each 19 cycles apart; in_ready returns the cycle after the first pop.
- Backpressure: hold out_ready=0 for 10 cycles in DONE.
  - out_valid and out_prod are stable; strobes stay 0; concurrent pushes are accepted until full.
- Reset asserted during SHIFT of job 2 of 3:
  - Immediately: all outputs at reset values, busy=0.
  - A subsequent 2 x 2 job yields 0x0004.
- Simultaneous push and pop with FIFO at DEPTH-1: occupancy is unchanged, and pointer wrap yields correct ordering over 3*DEPTH jobs.
